rational_reduce: RTL and testbench
==================================

# rational_reduce

Downstream stage of `algorithm_gcd`: consumes a gcd `g` together with the operand pair `(a, b)` that produced it, and emits the reduced pair `(a/g, b/g)` plus an exactness flag. It uses two parallel bit-serial restoring dividers that share one controller. It sits on the same valid/ready sync channel as the gcd core, so a gcd → rational_reduce chain reduces fractions end to end.

## Interface
- `N`, default `` `intN `` (8): operand and result width in bits; all values are unsigned.
- `clk`  in  1  rising-edge clock, the single clock domain.
- `nrst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream has `in0..in2` valid.
- `in_ready`  out  1  block can accept a new triple.
- `out_valid`  out  1  `out0..out2` are valid.
- `out_ready`  in  1  downstream accepts the result.
- `in0`  in  N  `g` (divisor; normally the gcd output).
- `in1`  in  N  `a` (dividend 0).
- `in2`  in  N  `b` (dividend 1).
- `out0`  out  N  `a / g`, truncated quotient.
- `out1`  out  N  `b / g`, truncated quotient.
- `out2`  out  1  exact flag: 1 iff both remainders are 0.
- Port grouping matches the `` `sync `` macro, so the block instantiates with `` `inst_sync(rational_reduce, …) ``.

## Operation
- FSM states: IDLE, DIV, DONE. Encoding is local to the module.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, latch `g`, `a`, `b` and clear both partial remainders.
  - If `g`==0, go to DONE with `out0`=0, `out1`=0, `out2`=1.
  - Otherwise set the step counter to N-1 and go to DIV.
- DIV, one restoring step per cycle per divider, MSB first:
  - r' = {r[N-1:0], dividend MSB}, with r held at N+1 bits.
  - If r' ≥ g: r ← r' − g and shift 1 into the quotient. Otherwise r ← r' and shift 0.
  - The dividend shifts left by one each step.
  - When counter==0, the step completes and the state goes to DONE. Otherwise the counter decrements.
- DONE:
  - `out_valid`=1. `out0`/`out1` hold the quotients.
  - `out2` = (r_a==0)&&(r_b==0).
  - Outputs stay stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1, go to IDLE.
- `in_ready` is high only in IDLE. There is no input acceptance in DIV or DONE, and no pass-through.
- Arithmetic:
  - The remainder register is N+1 bits, so r' never overflows.
  - Quotients are N bits. `a/1` = `a`, including 2^N−1.
  - `g` > `a` gives a quotient of 0 with remainder `a`, so `out2`=0 unless `a`==0.
- Inputs are sampled only at the accept edge. Changes to `in0..in2` afterwards are ignored.

## Timing
- Reset values (`nrst`=0, asynchronous): state=IDLE, `in_ready`=1, `out_valid`=0, `out0`=0, `out1`=0, `out2`=0, counter=0, remainders=0.
- Reset mid-DIV or mid-DONE:
  - Any in-flight result is discarded and never emitted.
  - After `nrst` releases, the first rising edge may accept new input.
- Latency, with E0 as the accept edge:
  - `g`≠0: DIV steps occur on E1..EN and `out_valid` rises after EN, i.e. N cycles.
  - `g`==0: `out_valid` rises after E1, i.e. 1 cycle.
- Throughput:
  - `g`≠0: with `out_ready` held at 1, one result per N+2 cycles.
  - `g`==0: one result per 3 cycles.
- Handshake:
  - A transfer occurs on an edge where valid&&ready.
  - `out_valid` never drops without a transfer.
  - `in_ready` deasserts the cycle after accept.
- `out_ready` asserted in IDLE or DIV has no effect.

## Structure
- Shared definitions live in `primitives.v`, not in this module: `` `intN ``, `` `intT ``, `` `true ``/`` `false `` and the `` `sync ``/`` `inst_sync `` port macros.
- FSM state encodings are local parameters inside the module.
- Sub-module `udiv_step`:
  - Purely combinational one-bit restoring step.
  - Inputs: r (N+1), dividend MSB, g (N).
  - Outputs: next r (N+1), quotient bit.
  - Instantiated twice, once for `a` and once for `b`.
- Controller, counter (clog2(N) bits) and datapath registers live in `rational_reduce`.

## Test plan
All cases use N=8.
- Accept g=7, a=21, b=35 with `out_ready`=1 → exactly 8 cycles later `out_valid`=1 with `out0`=3, `out1`=5, `out2`=1. It returns to IDLE the next edge.
- g=0, a=0, b=0 → `out_valid` 1 cycle after accept with `out0`=0, `out1`=0, `out2`=1.
- g=4, a=21, b=35 → `out0`=5, `out1`=8, `out2`=0.
- g=1, a=255, b=254 → `out0`=255, `out1`=254, `out2`=1. Confirms the N+1-bit remainder handles the full range.
- Backpressure on g=7, a=21, b=35 with `out_ready`=0 for 5 cycles after `out_valid` rises:
  - Outputs and `out_valid` hold steady and `in_ready` stays 0.
  - When `out_ready`=1, the transfer happens, then `in_ready`=1.
  - Changing `in1` during DIV does not alter the result.
- Pull `nrst` low 3 cycles into DIV → `out_valid`=0 and `in_ready`=1 immediately. No stale result appears later. A following g=7, a=21, b=35 still yields 3, 5, 1.

Source files
------------

// File: rtl/rational_reduce_pkg.sv
// rational_reduce_pkg: shared width default and sizing helper for the
// rational_reduce block (controller, interface and divider step).
package rational_reduce_pkg;

  // Default operand / result width.
  localparam int RR_N = 8;

  // Step-counter width: enough to hold N-1, never narrower than one bit.
  function automatic int rr_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rational_reduce_if.sv
// rational_reduce_if: valid/ready sync channel of rational_reduce.
//   in_valid/in_ready   : input handshake for the triple in0 (g), in1 (a), in2 (b)
//   out_valid/out_ready : output handshake for out0 (a/g), out1 (b/g), out2 (exact)
// master = upstream/downstream side, slave = the reducer itself.
interface rational_reduce_if import rational_reduce_pkg::*; #(
  parameter int N = RR_N
);
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] in0;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic [N-1:0] out0;
  logic [N-1:0] out1;
  logic         out2;

  modport master (
    output in_valid, in0, in1, in2, out_ready,
    input  in_ready, out_valid, out0, out1, out2
  );

  modport slave (
    input  in_valid, in0, in1, in2, out_ready,
    output in_ready, out_valid, out0, out1, out2
  );
endinterface

// File: rtl/rational_reduce_udiv_step.sv
// udiv_step: one combinational restoring-division step.
//   r       in  N+1  partial remainder
//   dvd_msb in  1    dividend bit shifted in this step
//   g       in  N    divisor
//   r_nxt   out N+1  updated remainder
//   q       out 1    quotient bit produced by this step
module udiv_step import rational_reduce_pkg::*; #(
  parameter int N = RR_N
) (
  input  logic [N:0]   r,
  input  logic         dvd_msb,
  input  logic [N-1:0] g,
  output logic [N:0]   r_nxt,
  output logic         q
);
  logic [N:0] r_sh;
  // The remainder is always < g, so its top bit is zero and drops out of the shift.
  logic       unused_r_top;

  assign unused_r_top = r[N];
  assign r_sh         = {r[N-1:0], dvd_msb};
  assign q            = (r_sh >= {1'b0, g});
  assign r_nxt        = q ? (r_sh - {1'b0, g}) : r_sh;
endmodule

// File: rtl/rational_reduce.sv
// rational_reduce: reduces (a, b) by their gcd g into (a/g, b/g) plus an
// exactness flag, using two bit-serial restoring dividers on one controller.
//   clk  in  clock
//   nrst in  asynchronous active-low reset
//   bus  slave modport of rational_reduce_if (in0=g, in1=a, in2=b;
//        out0=a/g, out1=b/g, out2=both remainders zero)
module rational_reduce import rational_reduce_pkg::*; #(
  parameter int N = RR_N
) (
  input  logic             clk,
  input  logic             nrst,
  rational_reduce_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, DONE = 2'd2} state_t;

  localparam int CW = rr_cnt_w(N);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      g_q;
  logic              g_zero;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              exact_q;
  // Per lane the dividend register doubles as the quotient register:
  // dividend bits leave at the top while quotient bits enter at the bottom.
  logic [1:0][N-1:0] dvd_q;
  logic [1:0][N-1:0] dvd_in;
  logic [1:0][N:0]   rem_q;
  logic [1:0][N:0]   rem_nxt;
  logic [1:0]        qbit;

  assign dvd_in[0] = bus.in1;
  assign dvd_in[1] = bus.in2;

  generate
    for (genvar i = 0; i < 2; i++) begin : g_lane
      udiv_step #(.N(N)) u_step (
        .r       (rem_q[i]),
        .dvd_msb (dvd_q[i][N-1]),
        .g       (g_q),
        .r_nxt   (rem_nxt[i]),
        .q       (qbit[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      cnt         <= '0;
      g_q         <= '0;
      g_zero      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      exact_q     <= 1'b0;
      dvd_q       <= '0;
      rem_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            g_q        <= bus.in0;
            g_zero     <= (bus.in0 == '0);
            rem_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= DIV;
            for (int i = 0; i < 2; i++)
              dvd_q[i] <= (bus.in0 == '0) ? '0 : dvd_in[i];
            // A zero divisor spends a single bookkeeping cycle in DIV with
            // the datapath frozen, giving its one-cycle result latency.
            cnt <= (bus.in0 == '0) ? '0 : CW'(N - 1);
          end
        end
        DIV: begin
          if (!g_zero) begin
            for (int i = 0; i < 2; i++) begin
              rem_q[i] <= rem_nxt[i];
              dvd_q[i] <= {dvd_q[i][N-2:0], qbit[i]};
            end
          end
          if (cnt == '0) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            exact_q     <= g_zero || (rem_nxt == '0);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out0      = dvd_q[0];
  assign bus.out1      = dvd_q[1];
  assign bus.out2      = exact_q;
endmodule

// File: tb/tb_rational_reduce.sv
module tb_rational_reduce;
  localparam int N = 8;

  typedef struct {
    logic [N-1:0] q0;
    logic [N-1:0] q1;
    logic         ex;
    int           acc;
    int           lat;
    int           bp;
  } exp_t;

  logic clk;
  logic nrst;
  int   cyc;
  int   checks;
  int   failures;
  bit   mon_off;
  exp_t q[$];

  rational_reduce_if #(.N(N)) bus ();

  rational_reduce #(.N(N)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: plain integer division and modulus.
  function automatic exp_t model(input int g, input int a, input int b, input int bp);
    exp_t e;
    if (g == 0) begin
      e.q0 = '0; e.q1 = '0; e.ex = 1'b1; e.lat = 1;
    end else begin
      e.q0 = N'(a / g); e.q1 = N'(b / g);
      e.ex = ((a % g) == 0) && ((b % g) == 0);
      e.lat = N;
    end
    e.bp  = bp;
    e.acc = 0;
    return e;
  endfunction

  task automatic scramble();
    bus.in0 = N'($urandom);
    bus.in1 = N'($urandom);
    bus.in2 = N'($urandom);
  endtask

  // Called at a negedge; returns at a negedge `post`+1 cycles after the accept.
  task automatic send(input int g, input int a, input int b, input int bp, input int post);
    exp_t e;
    int   w;
    bus.in_valid = 1'b1;
    bus.in0 = N'(g); bus.in1 = N'(a); bus.in2 = N'(b);
    w = 0;
    while (!bus.in_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      chk("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(g, a, b, bp);
    e.acc = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    bus.in_valid = 1'b0;
    scramble();
    repeat (post) begin
      @(negedge clk);
      scramble();
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() > 0 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (q.size() > 0) chk("drain_timeout", q.size(), 0);
  endtask

  // Monitor / scoreboard: runs just after each falling edge, decides out_ready
  // and checks whatever transfers on the next rising edge.
  int           vcnt;
  bit           prev_ov;
  bit           prev_xfer;
  int           prev_size;
  logic [N-1:0] h0, h1;
  logic         h2;

  initial begin
    exp_t e;
    bit   xfer;
    vcnt = 0; prev_ov = 0; prev_xfer = 0; prev_size = 0;
    h0 = '0; h1 = '0; h2 = 1'b0;
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_off) begin
        q.delete();
        prev_size = 0; prev_ov = 0; prev_xfer = 0; vcnt = 0;
        bus.out_ready = 1'b0;
      end else begin
        chk("in_ready", int'(bus.in_ready), int'(prev_size == 0));
        if (prev_ov && !prev_xfer) begin
          chk("hold_valid", int'(bus.out_valid), 1);
          chk("hold_out0", int'(bus.out0), int'(h0));
          chk("hold_out1", int'(bus.out1), int'(h1));
          chk("hold_out2", int'(bus.out2), int'(h2));
        end
        if (prev_xfer) chk("valid_drop_after_xfer", int'(bus.out_valid), 0);
        if (bus.out_valid && !prev_ov) begin
          chk("result_expected", q.size() > 0 ? 1 : 0, 1);
          if (q.size() > 0) chk("latency", cyc - q[0].acc, q[0].lat);
        end
        xfer = 1'b0;
        if (bus.out_valid && q.size() > 0) begin
          bus.out_ready = (vcnt >= q[0].bp);
          vcnt++;
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
          vcnt = 0;
        end
        if (bus.out_valid && bus.out_ready && q.size() > 0) begin
          e = q.pop_front();
          chk("out0_quot_a", int'(bus.out0), int'(e.q0));
          chk("out1_quot_b", int'(bus.out1), int'(e.q1));
          chk("out2_exact", int'(bus.out2), int'(e.ex));
          xfer = 1'b1;
          vcnt = 0;
        end
        prev_ov   = bus.out_valid;
        prev_xfer = xfer;
        h0 = bus.out0; h1 = bus.out1; h2 = bus.out2;
        prev_size = q.size();
      end
    end
  end

  initial begin
    int g;
    checks = 0; failures = 0;
    mon_off = 1'b1;
    nrst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in0 = '0; bus.in1 = '0; bus.in2 = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out0", int'(bus.out0), 0);
    chk("rst_out1", int'(bus.out1), 0);
    chk("rst_out2", int'(bus.out2), 0);
    nrst = 1'b1;
    mon_off = 1'b0;
    @(negedge clk);

    send(7, 21, 35, 0, 1);
    send(0, 0, 0, 0, 1);
    send(4, 21, 35, 0, 1);
    send(1, 255, 254, 0, 1);
    send(200, 13, 0, 0, 1);
    send(255, 255, 254, 0, 1);
    send(7, 21, 35, 5, 2);
    send(0, 99, 42, 2, 0);

    // Reset while dividing: result dropped, block immediately idle.
    drain();
    send(7, 21, 35, 0, 0);
    repeat (2) @(negedge clk);
    mon_off = 1'b1;
    nrst = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    chk("midrst_out0", int'(bus.out0), 0);
    @(negedge clk);
    nrst = 1'b1;
    mon_off = 1'b0;
    send(7, 21, 35, 0, 1);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       g = 0;
        1, 2, 3: g = int'($urandom_range(1, 15));
        default: g = int'($urandom_range(1, 255));
      endcase
      send(g, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    drain();
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
